// File: rtl/sass_voice_alloc_pkg.sv
// Shared types and constants for the SaSS polyphonic voice allocator.
// A voice is a small record; the helpers keep key-to-note mapping and popcount in one place.
package sass_voice_alloc_pkg;

  localparam int NUM_KEYS   = 13;
  localparam int NUM_VOICES = 4;
  localparam int NOTE_W     = 4;
  localparam int AGE_W      = 3;
  localparam int KEY_W      = $clog2(NUM_KEYS);
  localparam int VIDX_W     = $clog2(NUM_VOICES);
  localparam int CNT_W      = 3;

  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [AGE_W-1:0]  age_t;
  typedef logic [KEY_W-1:0]  key_idx_t;
  typedef logic [VIDX_W-1:0] voice_idx_t;

  localparam note_t NOTE_REST = '0;
  localparam age_t  AGE_MAX   = '1;

  typedef struct packed {
    logic     active;
    key_idx_t owner;
    note_t    note;
    age_t     age;
  } voice_t;

  typedef enum logic [1:0] {
    SVC_NONE,
    SVC_OFF,
    SVC_ON
  } svc_e;

  // Key k sounds note k+1 so that code 0 stays free for "rest".
  function automatic note_t key_to_note(input key_idx_t k);
    return note_t'(k) + note_t'(1);
  endfunction

  function automatic logic [CNT_W-1:0] count_active(input logic [NUM_VOICES-1:0] act);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int v = 0; v < NUM_VOICES; v++) n = n + CNT_W'(act[v]);
    return n;
  endfunction

endpackage

// File: rtl/sass_voice_alloc_if.sv
// Key/voice bundle between the allocator and its environment.
// The allocator is the slave: it consumes keys and control, produces voice state.
interface sass_voice_alloc_if;
  import sass_voice_alloc_pkg::*;

  logic                         en;
  logic [NUM_KEYS-1:0]          key_i;
  logic                         seq_on;
  logic [NUM_VOICES*NOTE_W-1:0] voice_note_o;
  logic [NUM_VOICES-1:0]        voice_active_o;
  logic [CNT_W-1:0]             active_count_o;
  logic                         steal_o;
  logic                         busy_o;

  modport master (
    output en, key_i, seq_on,
    input  voice_note_o, voice_active_o, active_count_o, steal_o, busy_o
  );

  modport slave (
    input  en, key_i, seq_on,
    output voice_note_o, voice_active_o, active_count_o, steal_o, busy_o
  );
endinterface

// File: rtl/sass_voice_alloc_pick.sv
// Combinational voice chooser: first free eligible voice, and the oldest eligible voice
// (maximum age, lowest index on ties) for stealing.
module sass_voice_pick
  import sass_voice_alloc_pkg::*;
(
  input  logic [NUM_VOICES-1:0]       active_i,
  input  logic [NUM_VOICES*AGE_W-1:0] age_i,
  input  logic [NUM_VOICES-1:0]       eligible_i,
  output voice_idx_t                  first_free_idx_o,
  output logic                        free_found_o,
  output voice_idx_t                  oldest_idx_o
);

  age_t best_age;
  logic best_found;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    first_free_idx_o = '0;
    free_found_o     = 1'b0;
    oldest_idx_o     = '0;
    best_age         = '0;
    best_found       = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (eligible_i[v] && !active_i[v] && !free_found_o) begin
        first_free_idx_o = voice_idx_t'(v);
        free_found_o     = 1'b1;
      end
      // Strict compare keeps the lowest index on equal ages.
      if (eligible_i[v] && (!best_found || age_i[v*AGE_W +: AGE_W] > best_age)) begin
        oldest_idx_o = voice_idx_t'(v);
        best_age     = age_i[v*AGE_W +: AGE_W];
        best_found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sass_voice_alloc.sv
// SaSS voice allocator: key edge detection, pending key-on/off queues, one event serviced
// per cycle into a four-entry voice table with free-first / oldest-steal allocation.
module sass_voice_alloc
  import sass_voice_alloc_pkg::*;
(
  input  logic          hwclk,
  input  logic          rst,
  sass_voice_alloc_if.slave bus
);

  logic [NUM_KEYS-1:0]          key_prev_q, pend_on_q, pend_on_d, pend_off_q, pend_off_d;
  logic [NUM_KEYS-1:0]          rise, fall;
  voice_t                       voices_q [NUM_VOICES];
  voice_t                       voices_d [NUM_VOICES];
  logic                         steal_q, steal_d;
  svc_e                         svc;
  key_idx_t                     svc_key;
  logic                         owner_hit, free_found;
  voice_idx_t                   owner_idx, first_free_idx, oldest_idx, alloc_idx;
  logic [NUM_VOICES-1:0]        act_vec, elig_vec;
  logic [NUM_VOICES*AGE_W-1:0]  age_vec;
  logic [NUM_VOICES*NOTE_W-1:0] note_vec;

  assign rise = bus.key_i & ~key_prev_q;
  assign fall = ~bus.key_i & key_prev_q;

  always_comb begin
    act_vec  = '0;
    age_vec  = '0;
    note_vec = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      act_vec[v]                 = voices_q[v].active;
      age_vec[v*AGE_W +: AGE_W]  = voices_q[v].age;
      note_vec[v*NOTE_W +: NOTE_W] = voices_q[v].note;
    end
    elig_vec    = '1;
    elig_vec[0] = ~bus.seq_on;
  end

  sass_voice_pick u_pick (
    .active_i         (act_vec),
    .age_i            (age_vec),
    .eligible_i       (elig_vec),
    .first_free_idx_o (first_free_idx),
    .free_found_o     (free_found),
    .oldest_idx_o     (oldest_idx)
  );

  // Key-offs outrank key-ons; descending scans leave the lowest index as the winner.
  always_comb begin
    svc     = SVC_NONE;
    svc_key = '0;
    for (int k = NUM_KEYS-1; k >= 0; k--) begin
      if (pend_on_q[k]) begin
        svc     = SVC_ON;
        svc_key = key_idx_t'(k);
      end
    end
    for (int k = NUM_KEYS-1; k >= 0; k--) begin
      if (pend_off_q[k]) begin
        svc     = SVC_OFF;
        svc_key = key_idx_t'(k);
      end
    end
  end

  always_comb begin
    owner_hit = 1'b0;
    owner_idx = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voices_q[v].active && voices_q[v].owner == svc_key && !owner_hit) begin
        owner_hit = 1'b1;
        owner_idx = voice_idx_t'(v);
      end
    end
  end

  always_comb begin
    voices_d   = voices_q;
    pend_on_d  = pend_on_q;
    pend_off_d = pend_off_q;
    steal_d    = 1'b0;
    alloc_idx  = free_found ? first_free_idx : oldest_idx;

    unique case (svc)
      SVC_OFF: begin
        pend_off_d[svc_key] = 1'b0;
        if (owner_hit) voices_d[owner_idx] = '0;
      end
      SVC_ON: begin
        pend_on_d[svc_key] = 1'b0;
        if (owner_hit) begin
          voices_d[owner_idx].age = '0;
        end else begin
          steal_d = ~free_found;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_idx_t'(v) == alloc_idx) begin
              voices_d[v] = '{active: 1'b1, owner: svc_key, note: key_to_note(svc_key), age: '0};
            end else if (voices_q[v].active && voices_q[v].age != AGE_MAX) begin
              voices_d[v].age = voices_q[v].age + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase

    // Fresh edges override whatever was just serviced for the same key.
    pend_on_d  = (pend_on_d  | rise) & ~fall;
    pend_off_d = (pend_off_d | fall) & ~rise;

    if (bus.seq_on) voices_d[0] = '0;

    if (!bus.en) begin
      pend_on_d  = '0;
      pend_off_d = '0;
      steal_d    = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) voices_d[v] = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      key_prev_q <= '0;
      pend_on_q  <= '0;
      pend_off_q <= '0;
      steal_q    <= 1'b0;
      // NOTE: the voice table is a handful of flops, not a RAM, so it is reset like any register.
      for (int v = 0; v < NUM_VOICES; v++) voices_q[v] <= '0;
    end else begin
      key_prev_q <= bus.key_i;
      pend_on_q  <= pend_on_d;
      pend_off_q <= pend_off_d;
      steal_q    <= steal_d;
      for (int v = 0; v < NUM_VOICES; v++) voices_q[v] <= voices_d[v];
    end
  end

  assign bus.voice_note_o   = note_vec;
  assign bus.voice_active_o = act_vec;
  assign bus.active_count_o = count_active(act_vec);
  assign bus.steal_o        = steal_q;
  assign bus.busy_o         = |pend_on_q | |pend_off_q;

endmodule

// File: tb/tb_sass_voice_alloc.sv
// Randomised and directed bench for sass_voice_alloc against a behavioural voice-table model.
module tb_sass_voice_alloc;
  import sass_voice_alloc_pkg::*;

  logic hwclk = 1'b0;
  logic rst;
  always #5 hwclk = ~hwclk;

  sass_voice_alloc_if bus ();

  sass_voice_alloc dut (
    .hwclk (hwclk),
    .rst   (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural model: pending sets, and voices as (held?, key, age) triples.
  bit m_prev [NUM_KEYS];
  bit m_pon  [NUM_KEYS];
  bit m_poff [NUM_KEYS];
  bit m_act  [NUM_VOICES];
  int m_own  [NUM_VOICES];
  int m_age  [NUM_VOICES];
  bit m_steal;

  task automatic model_clear_voices();
    for (int v = 0; v < NUM_VOICES; v++) begin
      m_act[v] = 0; m_own[v] = 0; m_age[v] = 0;
    end
  endtask

  task automatic model_edge();
    int ev;
    int key;
    int tgt;
    bit hit;
    if (rst) begin
      for (int k = 0; k < NUM_KEYS; k++) begin m_prev[k] = 0; m_pon[k] = 0; m_poff[k] = 0; end
      model_clear_voices();
      m_steal = 0;
      return;
    end
    if (!bus.en) begin
      for (int k = 0; k < NUM_KEYS; k++) begin m_prev[k] = bus.key_i[k]; m_pon[k] = 0; m_poff[k] = 0; end
      model_clear_voices();
      m_steal = 0;
      return;
    end
    ev = 0; key = -1;
    for (int k = 0; k < NUM_KEYS; k++) if (m_poff[k]) begin ev = 1; key = k; break; end
    if (ev == 0)
      for (int k = 0; k < NUM_KEYS; k++) if (m_pon[k]) begin ev = 2; key = k; break; end
    if (ev == 1) m_poff[key] = 0;
    if (ev == 2) m_pon[key] = 0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (bus.key_i[k] && !m_prev[k]) begin m_pon[k] = 1; m_poff[k] = 0; end
      else if (!bus.key_i[k] && m_prev[k]) begin m_poff[k] = 1; m_pon[k] = 0; end
      m_prev[k] = bus.key_i[k];
    end
    m_steal = 0;
    if (ev == 1) begin
      for (int v = 0; v < NUM_VOICES; v++)
        if (m_act[v] && m_own[v] == key) begin m_act[v] = 0; m_age[v] = 0; end
    end else if (ev == 2) begin
      hit = 0;
      for (int v = 0; v < NUM_VOICES; v++)
        if (m_act[v] && m_own[v] == key) begin m_age[v] = 0; hit = 1; end
      if (!hit) begin
        tgt = -1;
        for (int v = (bus.seq_on ? 1 : 0); v < NUM_VOICES; v++)
          if (!m_act[v]) begin tgt = v; break; end
        if (tgt < 0) begin
          m_steal = 1;
          for (int v = (bus.seq_on ? 1 : 0); v < NUM_VOICES; v++)
            if (tgt < 0 || m_age[v] > m_age[tgt]) tgt = v;
        end
        for (int v = 0; v < NUM_VOICES; v++)
          if (v != tgt && m_act[v] && m_age[v] < (1 << AGE_W) - 1) m_age[v]++;
        m_act[tgt] = 1; m_own[tgt] = key; m_age[tgt] = 0;
      end
    end
    if (bus.seq_on) begin m_act[0] = 0; m_age[0] = 0; end
  endtask

  task automatic compare_all(input string tag);
    logic [NUM_VOICES*NOTE_W-1:0] e_notes;
    logic [NUM_VOICES-1:0]        e_act;
    int                           e_cnt;
    bit                           e_busy;
    e_notes = '0; e_act = '0; e_cnt = 0; e_busy = 0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      e_act[v] = m_act[v];
      if (m_act[v]) begin
        e_notes[v*NOTE_W +: NOTE_W] = note_t'(m_own[v] + 1);
        e_cnt++;
      end
    end
    for (int k = 0; k < NUM_KEYS; k++) e_busy |= m_pon[k] | m_poff[k];
    check({tag, "/notes"}, 32'(bus.voice_note_o),   32'(e_notes));
    check({tag, "/active"}, 32'(bus.voice_active_o), 32'(e_act));
    check({tag, "/count"}, 32'(bus.active_count_o),  32'(e_cnt));
    check({tag, "/steal"}, 32'(bus.steal_o),         32'(m_steal));
    check({tag, "/busy"},  32'(bus.busy_o),          32'(e_busy));
  endtask

  task automatic cycle(input string tag, input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge hwclk);
      model_edge();
      #1;
      compare_all(tag);
    end
  endtask

  logic [NUM_KEYS-1:0] keys;
  bit saw_note8;

  initial begin
    rst = 1'b1; bus.en = 1'b1; bus.seq_on = 1'b0; keys = '0; bus.key_i = keys;
    cycle("reset", 2);
    check("reset_notes", 32'(bus.voice_note_o), 32'h0);
    rst = 1'b0;

    // Single key: note 5 on voice 0 two edges after the press.
    keys[4] = 1'b1; bus.key_i = keys;
    cycle("s1", 2);
    check("s1_note_v0", 32'(bus.voice_note_o[3:0]), 32'd5);
    check("s1_count", 32'(bus.active_count_o), 32'd1);
    keys = '0; bus.key_i = keys;
    cycle("s1_rel", 3);

    // Four simultaneous presses fill voices 0..3 in key order.
    keys[3:0] = 4'b1111; bus.key_i = keys;
    cycle("s2", 5);
    check("s2_notes", 32'(bus.voice_note_o), 32'h4321);

    // All busy: key 9 steals the oldest (voice 0); releasing stolen key 0 is a no-op.
    keys[9] = 1'b1; bus.key_i = keys;
    cycle("s3", 2);
    check("s3_steal", 32'(bus.steal_o), 32'd1);
    cycle("s3", 1);
    check("s3_notes", 32'(bus.voice_note_o), 32'h432A);
    keys[0] = 1'b0; bus.key_i = keys;
    cycle("s3_rel", 3);
    check("s3_rel_notes", 32'(bus.voice_note_o), 32'h432A);

    // Sequencer reserves voice 0; new keys go only to voices 1..3.
    bus.seq_on = 1'b1;
    cycle("s4_seq", 1);
    check("s4_v0_rest", 32'(bus.voice_note_o[3:0]), 32'd0);
    keys[8:5] = 4'b1111; bus.key_i = keys;
    cycle("s4_keys", 6);
    check("s4_v0_idle", 32'(bus.voice_active_o[0]), 32'd0);
    bus.seq_on = 1'b0; keys = '0; bus.key_i = keys;
    cycle("s4_rel", 12);

    // A tap on key 7 behind a backlog must never sound.
    saw_note8 = 0;
    keys[2:0] = 3'b111; bus.key_i = keys;
    cycle("s5", 1);
    keys[7] = 1'b1; bus.key_i = keys;
    cycle("s5_tap", 1);
    keys[7] = 1'b0; bus.key_i = keys;
    for (int i = 0; i < 8; i++) begin
      cycle("s5_drain", 1);
      for (int v = 0; v < NUM_VOICES; v++)
        if (bus.voice_note_o[v*NOTE_W +: NOTE_W] == 4'd8) saw_note8 = 1;
    end
    check("s5_no_note8", 32'(saw_note8), 32'd0);
    check("s5_busy_clear", 32'(bus.busy_o), 32'd0);

    // Mid-operation reset with 3 voices active and events pending.
    keys[10] = 1'b1; keys[11] = 1'b1; bus.key_i = keys;
    cycle("s6", 1);
    rst = 1'b1;
    cycle("s6_rst", 1);
    check("s6_rst_notes", 32'(bus.voice_note_o), 32'h0);
    check("s6_rst_busy", 32'(bus.busy_o), 32'd0);
    rst = 1'b0;
    cycle("s6_after_rst", 8);
    bus.en = 1'b0;
    cycle("s6_en_low", 1);
    check("s6_en_notes", 32'(bus.voice_note_o), 32'h0);
    bus.en = 1'b1;
    cycle("s6_en_back", 5);
    check("s6_held_silent", 32'(bus.voice_active_o), 32'h0);
    keys = '0; bus.key_i = keys;
    cycle("s6_rel", 3);

    // Random key traffic with occasional sequencer, enable and reset activity.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NUM_KEYS; k++)
        if ($urandom_range(7) == 0) keys[k] = ~keys[k];
      bus.key_i = keys;
      if ($urandom_range(19) == 0) bus.seq_on = ~bus.seq_on;
      bus.en = ($urandom_range(39) != 0);
      rst    = ($urandom_range(149) == 0);
      cycle("rand", 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
